// File: rtl/operand_fetch_if.sv
// Operand-fetch handshake plus pipelined memory read port between the multiplier
// side (master) and the operand_fetch_unit (slave).
interface operand_fetch_if #(
    parameter int LEN        = 8,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
);
    logic                           fetch_row;
    logic                           fetch_col;
    logic [IDX_WIDTH-1:0]           idx;
    logic [ADDR_WIDTH-1:0]          base_a;
    logic [ADDR_WIDTH-1:0]          base_b;
    logic                           mem_stall;
    logic                           buf_valid;
    logic [LEN-1:0][DATA_WIDTH-1:0] mem_buffer;
    logic                           rd_req;
    logic [ADDR_WIDTH-1:0]          rd_addr;
    logic                           rd_gnt;
    logic                           rd_valid;
    logic [DATA_WIDTH-1:0]          rd_data;
    logic                           err;

    modport master (
        output fetch_row, fetch_col, idx, base_a, base_b, rd_gnt, rd_valid, rd_data,
        input  mem_stall, buf_valid, mem_buffer, rd_req, rd_addr, err
    );

    modport slave (
        input  fetch_row, fetch_col, idx, base_a, base_b, rd_gnt, rd_valid, rd_data,
        output mem_stall, buf_valid, mem_buffer, rd_req, rd_addr, err
    );
endinterface

// File: rtl/operand_fetch_unit.sv
// Services one row/column operand fetch at a time: issues LEN pipelined reads,
// collects the in-order returns into mem_buffer and stalls the requester until done.
module operand_fetch_unit #(
    parameter int LEN        = 8,
    parameter int ROWS       = 8,
    parameter int COLS       = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int IDX_WIDTH  = 4,
    parameter int MAX_OUT    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_fetch_if.slave bus
);
    localparam int CW = $clog2(((LEN > MAX_OUT) ? LEN : MAX_OUT) + 2);
    localparam int SW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0]        LEN_C  = CW'(LEN);
    localparam logic [CW-1:0]        MAX_C  = CW'(MAX_OUT);
    localparam logic [IDX_WIDTH:0]   ROWS_C = (IDX_WIDTH+1)'(ROWS);
    localparam logic [IDX_WIDTH:0]   COLS_C = (IDX_WIDTH+1)'(COLS);

    typedef enum logic {IDLE, FETCH} state_t;

    state_t                state;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         received;
    logic [CW-1:0]         outstanding;
    logic [ADDR_WIDTH-1:0] stride;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic                  req_any;
    logic                  idx_ok;
    logic                  accept;
    logic                  ret_ok;
    logic                  grant;
    logic                  last_ret;
    logic                  err_set;

    assign req_any = bus.fetch_row | bus.fetch_col;
    assign idx_ok  = bus.fetch_row ? ({1'b0, bus.idx} < ROWS_C) : ({1'b0, bus.idx} < COLS_C);
    assign accept  = (state == IDLE) && (bus.fetch_row ^ bus.fetch_col) && idx_ok;

    assign start_addr = bus.fetch_row
                      ? bus.base_a + ADDR_WIDTH'(bus.idx) * ADDR_WIDTH'(LEN)
                      : bus.base_b + ADDR_WIDTH'(bus.idx);

    assign outstanding = issued - received;
    // A return in the current cycle frees a slot, so a grant may reuse it without a bubble.
    assign ret_ok   = bus.rd_valid && (state == FETCH) && (received != issued);
    assign grant    = bus.rd_req && bus.rd_gnt;
    assign last_ret = ret_ok && (received == LEN_C - 1'b1);
    assign err_set  = (req_any && !accept) || (bus.rd_valid && !ret_ok);

    assign bus.mem_stall = (state != IDLE) || accept;
    assign bus.rd_req    = (state == FETCH) && (issued < LEN_C) &&
                           ((outstanding - CW'(ret_ok)) < MAX_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            issued         <= '0;
            received       <= '0;
            stride         <= '0;
            bus.rd_addr    <= '0;
            bus.buf_valid  <= 1'b0;
            bus.err        <= 1'b0;
            bus.mem_buffer <= '0;
        end else begin
            bus.err <= err_set;
            if (accept) begin
                state         <= FETCH;
                issued        <= '0;
                received      <= '0;
                bus.rd_addr   <= start_addr;
                stride        <= bus.fetch_row ? ADDR_WIDTH'(1) : ADDR_WIDTH'(COLS);
                bus.buf_valid <= 1'b0;
            end else if (state == FETCH) begin
                if (grant) begin
                    issued      <= issued + 1'b1;
                    bus.rd_addr <= bus.rd_addr + stride;
                end
                if (ret_ok) begin
                    bus.mem_buffer[received[SW-1:0]] <= bus.rd_data;
                    received <= received + 1'b1;
                end
                if (last_ret) begin
                    state         <= IDLE;
                    bus.buf_valid <= 1'b1;
                end
            end
        end
    end
endmodule
